// File: rtl/calc_pkg.sv
// Shared opcode, state and width definitions for the calculator ALU datapath.
package calc_pkg;

  localparam int DEF_WIDTH  = 11;
  localparam int DEF_RWIDTH = 21;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    EXEC = ST_EXEC,
    DIV  = ST_DIV,
    DONE = ST_DONE
  } state_t;

endpackage

// File: rtl/seq_divider.sv
// Restoring shift-subtract divider datapath: one quotient bit per step, WIDTH steps.
// start loads the dividend; quot_next/rem_next expose the value the current step will commit.
module seq_divider #(
  parameter int WIDTH = 11
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             last,
  output logic [WIDTH-1:0] quot_next,
  output logic [WIDTH-1:0] rem_next
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   shifted;

  // rem stays below divisor, so the shifted partial remainder fits in WIDTH+1 bits.
  always_comb begin
    shifted   = {rem, quot[WIDTH-1]};
    quot_next = {quot[WIDTH-2:0], 1'b0};
    rem_next  = shifted[WIDTH-1:0];
    if (shifted >= {1'b0, divisor}) begin
      rem_next     = WIDTH'(shifted - {1'b0, divisor});
      quot_next[0] = 1'b1;
    end
  end

  assign last = (cnt == '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      quot <= '0;
      rem  <= '0;
      cnt  <= '0;
    end else if (start) begin
      quot <= dividend;
      rem  <= '0;
      cnt  <= CW'(WIDTH - 1);
    end else if (step) begin
      quot <= quot_next;
      rem  <= rem_next;
      if (cnt != '0) cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle ALU sequencer: add/sub/mul in one compute cycle, div over WIDTH steps.
// Status outputs are registered from the state, so done_strobe lands 2 (or WIDTH+2) edges after ex_strobe.
module alu_sequencer
  import calc_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int RWIDTH = DEF_RWIDTH
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ex_strobe,
  input  logic              clear_strobe,
  input  logic              ms_strobe,
  input  logic [1:0]        op_code,
  input  logic [WIDTH-1:0]  reg_A_bin,
  input  logic [WIDTH-1:0]  reg_B_bin,
  output logic              busy,
  output logic              done_strobe,
  output logic [RWIDTH-1:0] result,
  output logic [RWIDTH-1:0] remainder,
  output logic              remain,
  output logic              neg,
  output logic              div_zero,
  output logic              mem_load
);

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [1:0]       op_q;
  logic             pending;

  logic             div_start;
  logic             div_step;
  logic             div_last;
  logic [WIDTH-1:0] quot_next;
  logic [WIDTH-1:0] rem_next;

  assign div_start = (state == EXEC) && (op_q == OP_DIV) && (b_q != '0);
  assign div_step  = (state == DIV);

  seq_divider #(.WIDTH(WIDTH)) u_div (
    .clock     (clock),
    .reset     (reset),
    .start     (div_start),
    .step      (div_step),
    .dividend  (a_q),
    .divisor   (b_q),
    .last      (div_last),
    .quot_next (quot_next),
    .rem_next  (rem_next)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= OP_ADD;
      pending     <= 1'b0;
      busy        <= 1'b0;
      done_strobe <= 1'b0;
      result      <= '0;
      remainder   <= '0;
      remain      <= 1'b0;
      neg         <= 1'b0;
      div_zero    <= 1'b0;
      mem_load    <= 1'b0;
    end else if (clear_strobe) begin
      state       <= IDLE;
      pending     <= 1'b0;
      busy        <= 1'b0;
      done_strobe <= 1'b0;
      result      <= '0;
      remainder   <= '0;
      remain      <= 1'b0;
      neg         <= 1'b0;
      div_zero    <= 1'b0;
      mem_load    <= 1'b0;
    end else begin
      busy        <= (state == EXEC) || (state == DIV);
      done_strobe <= (state == DONE);
      mem_load    <= 1'b0;
      case (state)
        IDLE: begin
          if (ex_strobe) begin
            a_q   <= reg_A_bin;
            b_q   <= reg_B_bin;
            op_q  <= op_code;
            state <= EXEC;
            if (ms_strobe) pending <= 1'b1;
          end else if (ms_strobe) begin
            mem_load <= 1'b1;
          end
        end
        EXEC: begin
          if (ms_strobe) pending <= 1'b1;
          remainder <= '0;
          remain    <= 1'b0;
          neg       <= 1'b0;
          div_zero  <= 1'b0;
          state     <= DONE;
          case (op_q)
            OP_ADD: result <= RWIDTH'(a_q) + RWIDTH'(b_q);
            OP_SUB: begin
              result <= RWIDTH'(a_q) - RWIDTH'(b_q);
              neg    <= (a_q < b_q);
            end
            OP_MUL: result <= RWIDTH'(a_q) * RWIDTH'(b_q);
            default: begin
              if (b_q == '0) begin
                result   <= '0;
                div_zero <= 1'b1;
              end else begin
                // Previous result holds until the final divide step overwrites it.
                state <= DIV;
              end
            end
          endcase
        end
        DIV: begin
          if (ms_strobe) pending <= 1'b1;
          if (div_last) begin
            result    <= RWIDTH'(quot_next);
            remainder <= RWIDTH'(rem_next);
            remain    <= (rem_next != '0);
            state     <= DONE;
          end
        end
        DONE: begin
          // Deferred store fires alongside done_strobe, once the result has settled.
          if (pending || ms_strobe) mem_load <= 1'b1;
          pending <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench: expected results queued at issue, checked when done_strobe appears.
module tb_alu_sequencer;

  localparam int WIDTH  = 11;
  localparam int RWIDTH = 21;
  localparam logic [1:0] T_ADD = 2'b00, T_SUB = 2'b01, T_MUL = 2'b10, T_DIV = 2'b11;

  logic              clock;
  logic              reset;
  logic              ex_strobe;
  logic              clear_strobe;
  logic              ms_strobe;
  logic [1:0]        op_code;
  logic [WIDTH-1:0]  reg_A_bin;
  logic [WIDTH-1:0]  reg_B_bin;
  logic              busy;
  logic              done_strobe;
  logic [RWIDTH-1:0] result;
  logic [RWIDTH-1:0] remainder;
  logic              remain;
  logic              neg;
  logic              div_zero;
  logic              mem_load;

  alu_sequencer #(.WIDTH(WIDTH), .RWIDTH(RWIDTH)) dut (
    .clock        (clock),
    .reset        (reset),
    .ex_strobe    (ex_strobe),
    .clear_strobe (clear_strobe),
    .ms_strobe    (ms_strobe),
    .op_code      (op_code),
    .reg_A_bin    (reg_A_bin),
    .reg_B_bin    (reg_B_bin),
    .busy         (busy),
    .done_strobe  (done_strobe),
    .result       (result),
    .remainder    (remainder),
    .remain       (remain),
    .neg          (neg),
    .div_zero     (div_zero),
    .mem_load     (mem_load)
  );

  typedef struct {
    logic [RWIDTH-1:0] res;
    logic [RWIDTH-1:0] rem;
    logic              remain;
    logic              neg;
    logic              dz;
    int                issue;
    int                lat;
    int                bsy;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   edge_cnt = 0;
  int   done_cnt = 0;
  int   exp_done = 0;
  int   done_edge = -1;
  int   mem_cnt = 0;
  int   mem_edge = -1;
  int   busy_run = 0;
  int   busy_last = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) edge_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0d (0x%0h) expected=%0d (0x%0h) at edge %0d", tag, got, got, exp, exp, edge_cnt);
  endtask

  function automatic exp_t model(input logic [1:0] op, input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b, input int issue);
    exp_t e;
    e = '{res: '0, rem: '0, remain: 1'b0, neg: 1'b0, dz: 1'b0, issue: issue, lat: 2, bsy: 1};
    case (op)
      T_ADD: e.res = RWIDTH'(a) + RWIDTH'(b);
      T_SUB: begin
        e.res = RWIDTH'(a) - RWIDTH'(b);
        e.neg = (a < b);
      end
      T_MUL: e.res = RWIDTH'(a) * RWIDTH'(b);
      default: begin
        if (b == 0) begin
          e.dz = 1'b1;
        end else begin
          e.res    = RWIDTH'(a / b);
          e.rem    = RWIDTH'(a % b);
          e.remain = (a % b) != 0;
          e.lat    = WIDTH + 2;
          e.bsy    = WIDTH + 1;
        end
      end
    endcase
    return e;
  endfunction

  // Monitor: samples on the falling edge, away from the DUT's active edge.
  always @(negedge clock) begin
    exp_t e;
    if (busy) busy_run++;
    else begin
      if (busy_run > 0) busy_last = busy_run;
      busy_run = 0;
    end
    if (mem_load) begin
      mem_cnt++;
      mem_edge = edge_cnt;
    end
    if (done_strobe) begin
      done_cnt++;
      done_edge = edge_cnt;
      if (sb.size() == 0) begin
        check("spurious_done", 1, 0);
      end else begin
        e = sb.pop_front();
        check("result", 32'(result), 32'(e.res));
        check("remainder", 32'(remainder), 32'(e.rem));
        check("remain", 32'(remain), 32'(e.remain));
        check("neg", 32'(neg), 32'(e.neg));
        check("div_zero", 32'(div_zero), 32'(e.dz));
        check("latency", edge_cnt - e.issue, e.lat);
        check("busy_cycles", busy_last, e.bsy);
      end
    end
  end

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input bit push);
    op_code   = op;
    reg_A_bin = a;
    reg_B_bin = b;
    ex_strobe = 1'b1;
    if (push) begin
      sb.push_back(model(op, a, b, edge_cnt + 1));
      exp_done++;
    end
    step();
    ex_strobe = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 60 && done_cnt < exp_done; i++) step();
    check("done_seen", done_cnt, exp_done);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done_strobe), 0);
    check({tag, "_result"}, 32'(result), 0);
    check({tag, "_remainder"}, 32'(remainder), 0);
    check({tag, "_remain"}, 32'(remain), 0);
    check({tag, "_neg"}, 32'(neg), 0);
    check({tag, "_divzero"}, 32'(div_zero), 0);
    check({tag, "_memload"}, 32'(mem_load), 0);
  endtask

  initial begin
    int m0;
    int e;
    reset = 1'b1;
    ex_strobe = 1'b0;
    clear_strobe = 1'b0;
    ms_strobe = 1'b0;
    op_code = T_ADD;
    reg_A_bin = '0;
    reg_B_bin = '0;
    repeat (3) step();
    check_cleared("reset");
    reset = 1'b0;
    step();

    issue(T_ADD, 123, 456, 1); wait_done();
    issue(T_SUB, 5, 9, 1);     wait_done();
    issue(T_MUL, 999, 999, 1); wait_done();

    // Divide with a second execute request arriving at step 4; it must be dropped.
    issue(T_DIV, 100, 7, 1);
    repeat (4) step();
    op_code = T_ADD; reg_A_bin = 1; reg_B_bin = 1; ex_strobe = 1'b1;
    step();
    ex_strobe = 1'b0;
    wait_done();
    repeat (20) step();
    check("single_done", done_cnt, exp_done);

    issue(T_DIV, 5, 0, 1); wait_done();

    // Two stores during a divide collapse into one pulse alongside done_strobe.
    m0 = mem_cnt;
    issue(T_DIV, 200, 9, 1);
    repeat (3) step();
    ms_strobe = 1'b1; step(); ms_strobe = 1'b0;
    repeat (2) step();
    ms_strobe = 1'b1; step(); ms_strobe = 1'b0;
    wait_done();
    repeat (3) step();
    check("div_store_pulses", mem_cnt - m0, 1);
    check("div_store_edge", mem_edge, done_edge);

    m0 = mem_cnt;
    e = edge_cnt + 1;
    ms_strobe = 1'b1; step(); ms_strobe = 1'b0;
    step();
    check("idle_store_pulses", mem_cnt - m0, 1);
    check("idle_store_edge", mem_edge, e);

    // Clear at divide step 5 with a store pending.
    m0 = mem_cnt;
    issue(T_DIV, 100, 7, 0);
    repeat (2) step();
    ms_strobe = 1'b1; step(); ms_strobe = 1'b0;
    repeat (2) step();
    clear_strobe = 1'b1; step(); clear_strobe = 1'b0;
    check_cleared("clear");
    repeat (20) step();
    check("clear_no_store", mem_cnt - m0, 0);
    check("clear_no_done", done_cnt, exp_done);

    m0 = mem_cnt;
    ms_strobe = 1'b1;
    issue(T_SUB, 3, 7, 1);
    ms_strobe = 1'b0;
    wait_done();
    repeat (2) step();
    check("coincident_store_pulses", mem_cnt - m0, 1);
    check("coincident_store_edge", mem_edge, done_edge);

    // Asynchronous reset in the middle of a divide with a store pending.
    m0 = mem_cnt;
    issue(T_DIV, 999, 3, 0);
    repeat (2) step();
    ms_strobe = 1'b1; step(); ms_strobe = 1'b0;
    repeat (2) step();
    reset = 1'b1;
    #1;
    check_cleared("async_reset");
    step();
    reset = 1'b0;
    step();
    issue(T_DIV, 9, 3, 1);
    wait_done();
    repeat (5) step();
    check("reset_no_store", mem_cnt - m0, 0);
    check("scoreboard_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
